// File: rtl/aes_pkg.sv
// Shared types, per-mode constants and GF(2^8) helpers for the AES key-schedule engine.
// Build option: AES_KS_WIDE_EN enables AES-192/AES-256 support.
package aes_pkg;

  typedef enum logic [1:0] {
    AES128 = 2'd0,
    AES192 = 2'd1,
    AES256 = 2'd2
  } aes_mode_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

`ifdef AES_KS_WIDE_EN
  localparam int KS_STORE_WORDS = 60;
`else
  localparam int KS_STORE_WORDS = 44;
`endif

  function automatic logic [3:0] nk(input logic [1:0] mode);
    case (aes_mode_e'(mode))
      AES192:  nk = 4'd6;
      AES256:  nk = 4'd8;
      default: nk = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr(input logic [1:0] mode);
    case (aes_mode_e'(mode))
      AES192:  nr = 4'd12;
      AES256:  nr = 4'd14;
      default: nr = 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] total_words(input logic [1:0] mode);
    case (aes_mode_e'(mode))
      AES192:  total_words = 6'd52;
      AES256:  total_words = 6'd60;
      default: total_words = 6'd44;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) begin
        acc = acc ^ aa;
      end else begin
        acc = acc;
      end
      aa = xtime(aa);
    end
    gf_mul = acc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  import aes_pkg::*;

  logic [7:0] w_sq;
  logic [7:0] w_inv;

  // x^254 = x^2 * x^4 * ... * x^128 gives the inverse (and maps 0 to 0)
  always_comb begin
    w_sq  = i_byte;
    w_inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      w_sq  = gf_mul(w_sq, w_sq);
      w_inv = gf_mul(w_inv, w_sq);
    end
    o_byte = w_inv
           ^ {w_inv[6:0], w_inv[7]}
           ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]}
           ^ {w_inv[3:0], w_inv[7:4]}
           ^ 8'h63;
  end

endmodule

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four byte-wise S-box lookups.
module aes_sub_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  aes_sbox u_sbox3 (.i_byte(i_word[31:24]), .o_byte(o_word[31:24]));
  aes_sbox u_sbox2 (.i_byte(i_word[23:16]), .o_byte(o_word[23:16]));
  aes_sbox u_sbox1 (.i_byte(i_word[15:8]),  .o_byte(o_word[15:8]));
  aes_sbox u_sbox0 (.i_byte(i_word[7:0]),   .o_byte(o_word[7:0]));

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES key expansion, one schedule word per clock through a single SubWord path.
// Build option: AES_KS_WIDE_EN adds AES-192/AES-256 (60-word storage); otherwise AES-128 only.
module aes_key_schedule #(
  parameter int MAX_WORDS = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic         err,
  output logic [3:0]   nr,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);
  import aes_pkg::*;

  localparam int DEPTH = (MAX_WORDS < KS_STORE_WORDS) ? MAX_WORDS : KS_STORE_WORDS;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [5:0]  r_idx;
  logic [3:0]  r_mod;
  logic [7:0]  r_rcon;
  logic [3:0]  r_nk;
  logic [5:0]  r_total;
  logic [3:0]  r_nr;
  logic        r_busy;
  logic        r_done;
  logic        r_valid;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic        w_mode_ok;
  logic        w_start_ok;
  logic        w_start_bad;
  logic [3:0]  w_start_nk;
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic        w_rot_case;
  logic        w_sub8_case;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub_out;
  logic [31:0] w_t;
  logic [31:0] w_new;
  logic        w_last;
  logic [5:0]  w_rd_base;

`ifdef AES_KS_WIDE_EN
  assign w_mode_ok   = (mode != 2'd3);
  assign w_sub8_case = (r_nk == 4'd8) && (r_mod == 4'd4);
`else
  assign w_mode_ok   = (mode == 2'd0);
  assign w_sub8_case = 1'b0;
`endif

  assign w_start_ok  = start && (r_state == ST_IDLE) && w_mode_ok;
  assign w_start_bad = start && (r_state == ST_IDLE) && !w_mode_ok;
  assign w_start_nk  = aes_pkg::nk(mode);

  assign w_prev     = r_mem[r_idx - 6'd1];
  assign w_back     = r_mem[r_idx - {2'b00, r_nk}];
  assign w_rot_case = (r_mod == 4'd0);
  assign w_last     = (r_idx == (r_total - 6'd1));

  // The one SubWord instance serves both the RotWord case and the Nk=8 mid-block case
  assign w_sub_in = w_rot_case ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .i_word(w_sub_in),
    .o_word(w_sub_out)
  );

  // Select the temporary word t for the current schedule index
  always_comb begin
    w_t = w_prev;
    if (w_rot_case) begin
      w_t = w_sub_out ^ {r_rcon, 24'h000000};
    end else if (w_sub8_case) begin
      w_t = w_sub_out;
    end else begin
      w_t = w_prev;
    end
    w_new = w_back ^ w_t;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = ST_EXPAND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXPAND: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_EXPAND;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Index, mod-Nk counter, rcon and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= 6'd0;
      r_mod   <= 4'd0;
      r_rcon  <= RCON_INIT;
      r_nk    <= 4'd4;
      r_total <= 6'd44;
      r_nr    <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_start_bad;
      if (w_start_ok) begin
        r_idx   <= {2'b00, w_start_nk};
        r_mod   <= 4'd0;
        r_rcon  <= RCON_INIT;
        r_nk    <= w_start_nk;
        r_total <= aes_pkg::total_words(mode);
        r_nr    <= aes_pkg::nr(mode);
        r_valid <= 1'b0;
        r_busy  <= 1'b1;
      end else if (r_state == ST_EXPAND) begin
        r_idx <= r_idx + 6'd1;
        r_mod <= (r_mod == (r_nk - 4'd1)) ? 4'd0 : (r_mod + 4'd1);
        if (w_rot_case) begin
          r_rcon <= xtime(r_rcon);
        end
        if (w_last) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_valid <= 1'b1;
        end
      end
    end
  end

  // Schedule storage: key words loaded in parallel at start, then one word per cycle
  always_ff @(posedge clk) begin
    if (w_start_ok) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < w_start_nk) begin
          r_mem[6'(k)] <= key[255 - 32*k -: 32];
        end
      end
    end else if (r_state == ST_EXPAND) begin
      r_mem[r_idx] <= w_new;
    end
  end

  // Combinational round-key read; zero when nothing valid is held or index is past nr
  always_comb begin
    w_rd_base = {rd_round, 2'b00};
    if (r_valid && (rd_round <= r_nr)) begin
      rd_key = {r_mem[w_rd_base], r_mem[w_rd_base + 6'd1],
                r_mem[w_rd_base + 6'd2], r_mem[w_rd_base + 6'd3]};
    end else begin
      rd_key = 128'h0;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign valid = r_valid;
  assign err   = r_err;
  assign nr    = r_nr;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: FIPS-197 vectors plus random keys against a reference expansion.
module tb_aes_key_schedule;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         valid;
  logic         err;
  logic [3:0]   nr;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  sbox [256];
  logic [31:0] m_w [60];
  int          m_nr;
  logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  aes_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key(key),
    .busy(busy), .done(done), .valid(valid), .err(err), .nr(nr),
    .rd_round(rd_round), .rd_key(rd_key)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    rotl8 = (v << n) | (v >> (8 - n));
  endfunction

  // S-box table from the 3 / (1/3) generator walk, independent of the RTL inverse.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    subw = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic model_expand(input int mc, input logic [255:0] k);
    int nkm;
    int tot;
    logic [31:0] t;
    nkm  = 4 + 2 * mc;
    m_nr = 10 + 2 * mc;
    tot  = 4 * (m_nr + 1);
    for (int i = 0; i < nkm; i++) m_w[i] = k[255 - 32*i -: 32];
    for (int i = nkm; i < tot; i++) begin
      t = m_w[i-1];
      if (i % nkm == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nkm - 1], 24'h000000};
      else if (nkm == 8 && i % nkm == 4) t = subw(t);
      m_w[i] = m_w[i-nkm] ^ t;
    end
  endtask

  function automatic logic [255:0] rand_key();
    rand_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_start(input logic [1:0] m, input logic [255:0] k);
    mode  = m;
    key   = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int inject_at, input logic [255:0] k2, output int cyc);
    int bad;
    cyc = 0;
    bad = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) bad++;
      if (cyc == inject_at) begin
        start = 1'b1;
        mode  = 2'd0;
        key   = k2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("busy_window", 256'(bad), 256'd0);
    chk("busy_at_done", {255'd0, busy}, 256'd0);
  endtask

  task automatic check_sched(input int mc, input logic [255:0] k);
    logic [127:0] exp;
    model_expand(mc, k);
    chk("valid", {255'd0, valid}, 256'd1);
    chk("nr", {252'd0, nr}, 256'(m_nr));
    for (int r = 0; r < 16; r++) begin
      rd_round = 4'(r);
      #1;
      if (r <= m_nr) exp = {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
      else exp = 128'h0;
      chk($sformatf("rk_m%0d_r%0d", mc, r), {128'd0, rd_key}, {128'd0, exp});
    end
  endtask

  initial begin
    int cyc;
    int n_done;
    int mc;
    int nmodes;
    logic [255:0] k128;
    logic [255:0] ka;
    logic [255:0] kb;

    build_sbox();
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; key = '0; rd_round = 4'd0;
    #20;
    chk("rst_busy",  {255'd0, busy},  256'd0);
    chk("rst_done",  {255'd0, done},  256'd0);
    chk("rst_valid", {255'd0, valid}, 256'd0);
    chk("rst_err",   {255'd0, err},   256'd0);
    chk("rst_nr",    {252'd0, nr},    256'd0);
    chk("rst_rdkey", {128'd0, rd_key}, 256'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    do_start(2'd0, k128);
    wait_done(-1, '0, cyc);
    chk("lat128", 256'(cyc), 256'd40);
    rd_round = 4'd10; #1;
    chk("fips128_r10", {128'd0, rd_key}, {128'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    rd_round = 4'd0; #1;
    chk("fips128_r0", {128'd0, rd_key}, {128'd0, k128[255:128]});
    check_sched(0, k128);
    @(posedge clk); #1;
    chk("done_one_cycle", {255'd0, done}, 256'd0);

    do_start(2'd3, rand_key());
    chk("ill_err",   {255'd0, err},   256'd1);
    chk("ill_busy",  {255'd0, busy},  256'd0);
    chk("ill_valid", {255'd0, valid}, 256'd1);
    @(posedge clk); #1;
    chk("ill_err_drop", {255'd0, err}, 256'd0);
    chk("ill_busy2",    {255'd0, busy}, 256'd0);
    rd_round = 4'd10; #1;
    chk("ill_r10_kept", {128'd0, rd_key}, {128'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

`ifdef AES_KS_WIDE_EN
    nmodes = 3;
    do_start(2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
    wait_done(-1, '0, cyc);
    chk("lat192", 256'(cyc), 256'd46);
    chk("nr192", {252'd0, nr}, 256'd12);
    rd_round = 4'd12; #1;
    chk("fips192_w51", {224'd0, rd_key[31:0]}, {224'd0, 32'h01002202});
    rd_round = 4'd13; #1;
    chk("fips192_r13", {128'd0, rd_key}, 256'd0);
    check_sched(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
    @(posedge clk); #1;

    do_start(2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    wait_done(-1, '0, cyc);
    chk("lat256", 256'(cyc), 256'd52);
    rd_round = 4'd14; #1;
    chk("fips256_r14", {128'd0, rd_key}, {128'd0, 128'hfe4890d1e6188d0b046df344706c631e});
    check_sched(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    @(posedge clk); #1;
`else
    nmodes = 1;
    for (int m = 1; m < 3; m++) begin
      do_start(2'(m), rand_key());
      chk($sformatf("narrow_err_m%0d", m), {255'd0, err}, 256'd1);
      chk($sformatf("narrow_busy_m%0d", m), {255'd0, busy}, 256'd0);
      chk($sformatf("narrow_valid_m%0d", m), {255'd0, valid}, 256'd1);
      @(posedge clk); #1;
    end
`endif

    ka = rand_key();
    kb = rand_key();
    do_start(2'd0, ka);
    wait_done(10, kb, cyc);
    chk("lat_busy_start", 256'(cyc), 256'd40);
    check_sched(0, ka);
    @(posedge clk); #1;

    do_start(2'(nmodes - 1), rand_key());
    repeat (20) @(posedge clk);
    #20 rst_n = 1'b0;
    #1;
    rd_round = 4'd0; #1;
    chk("midrst_busy",  {255'd0, busy},  256'd0);
    chk("midrst_valid", {255'd0, valid}, 256'd0);
    chk("midrst_rdkey", {128'd0, rd_key}, 256'd0);
    #10 rst_n = 1'b1;
    n_done = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    chk("midrst_no_done", 256'(n_done), 256'd0);
    ka = rand_key();
    do_start(2'd0, ka);
    wait_done(-1, '0, cyc);
    chk("lat_after_rst", 256'(cyc), 256'd40);
    check_sched(0, ka);

    mc = $urandom_range(nmodes - 1, 0);
    ka = rand_key();
    do_start(2'(mc), ka);
    for (int n = 0; n < 8; n++) begin
      wait_done(-1, '0, cyc);
      chk($sformatf("lat_rand%0d", n), 256'(cyc), 256'(40 + 6 * mc));
      check_sched(mc, ka);
      if (n < 7) begin
        mc = $urandom_range(nmodes - 1, 0);
        ka = rand_key();
        do_start(2'(mc), ka);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
